// File: rtl/sun_pll_ctrl.sv
// sun_pll_ctrl: startup and lock controller for the SUN PLL ring oscillator.
// Powers up the oscillator, measures the divided feedback clock over a
// reference-clock window, binary-searches the VDD_ROSC DAC code and then
// tracks it by +/-1 LSB, flagging LOCK while the count stays within TOL.
module sun_pll_ctrl #(
  parameter int CODE_W     = 6,
  parameter int CNT_W      = 10,
  parameter int WIN_W      = 10,
  parameter int SETTLE_CYC = 16,
  parameter int TOL        = 2
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              EN,
  input  logic [CNT_W-1:0]  TARGET,
  input  logic [WIN_W-1:0]  WINDOW,
  input  logic              CK_FB,
  output logic              PWRUP,
  output logic [CODE_W-1:0] CODE,
  output logic [CNT_W-1:0]  COUNT,
  output logic              BUSY,
  output logic              LOCK
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

  localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [BIT_W-1:0]  BIT_TOP  = BIT_W'(CODE_W - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W:0]    TOL_X    = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    S_OFF,
    S_SETTLE,
    S_MEASURE,
    S_DECIDE
  } state_t;

  typedef enum logic {
    PH_SAR,
    PH_TRACK
  } phase_t;

  state_t              r_state, w_state_nxt;
  phase_t              r_phase, w_phase_nxt;
  logic [CODE_W-1:0]   r_code, w_code_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic                r_lock, w_lock_nxt;
  logic [BIT_W-1:0]    r_bit, w_bit_nxt;
  logic [SET_W-1:0]    r_set_cnt, w_set_cnt_nxt;
  logic [WIN_W-1:0]    r_win_cnt, w_win_cnt_nxt;
  logic [WIN_W-1:0]    r_win_last, w_win_last_nxt;
  logic [CNT_W-1:0]    r_edge_cnt, w_edge_cnt_nxt;
  logic [CNT_W-1:0]    r_target, w_target_nxt;
  logic                r_s1, r_s2, r_s3;

  logic                w_edge;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic [WIN_W-1:0]    w_win_len_m1;
  logic [CODE_W-1:0]   w_bit_mask;
  logic [CNT_W:0]      w_cnt_x, w_tgt_x;
  logic                w_below, w_too_low, w_too_high;

  // Datapath helpers: feedback edge, saturating count, window length, compares
  always_comb begin
    w_edge       = r_s2 & ~r_s3;
    w_cnt_inc    = (w_edge && (r_edge_cnt != '1)) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    w_win_len_m1 = (WINDOW == '0) ? '0 : WINDOW - WIN_W'(1);
    w_bit_mask   = CODE_W'(1) << r_bit;
    w_cnt_x      = {1'b0, r_count};
    w_tgt_x      = {1'b0, r_target};
    w_below      = r_count < r_target;
    // Bounds extended by one bit so TARGET +/- TOL never wraps
    w_too_low    = (w_cnt_x + TOL_X) < w_tgt_x;
    w_too_high   = w_cnt_x > (w_tgt_x + TOL_X);
  end

  // Next-state and register-update logic for the startup/lock sequencer
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_code_nxt     = r_code;
    w_count_nxt    = r_count;
    w_lock_nxt     = r_lock;
    w_bit_nxt      = r_bit;
    w_set_cnt_nxt  = r_set_cnt;
    w_win_cnt_nxt  = r_win_cnt;
    w_win_last_nxt = r_win_last;
    w_edge_cnt_nxt = r_edge_cnt;
    w_target_nxt   = r_target;

    if (!EN) begin
      w_state_nxt    = S_OFF;
      w_phase_nxt    = PH_SAR;
      w_code_nxt     = CODE_MID;
      w_lock_nxt     = 1'b0;
      w_bit_nxt      = BIT_TOP;
      w_set_cnt_nxt  = '0;
      w_win_cnt_nxt  = '0;
      w_edge_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt   = S_SETTLE;
          w_phase_nxt   = PH_SAR;
          w_code_nxt    = CODE_MID;
          w_lock_nxt    = 1'b0;
          w_bit_nxt     = BIT_TOP;
          w_set_cnt_nxt = '0;
        end
        S_SETTLE: begin
          if (r_set_cnt == SET_LAST) begin
            w_state_nxt    = S_MEASURE;
            w_set_cnt_nxt  = '0;
            w_win_cnt_nxt  = '0;
            w_edge_cnt_nxt = '0;
            w_win_last_nxt = w_win_len_m1;
          end else begin
            w_set_cnt_nxt = r_set_cnt + SET_W'(1);
          end
        end
        S_MEASURE: begin
          w_edge_cnt_nxt = w_cnt_inc;
          if (r_win_cnt == r_win_last) begin
            // Result includes an edge seen in the final window cycle
            w_count_nxt   = w_cnt_inc;
            w_target_nxt  = TARGET;
            w_win_cnt_nxt = '0;
            w_state_nxt   = S_DECIDE;
          end else begin
            w_win_cnt_nxt = r_win_cnt + WIN_W'(1);
          end
        end
        S_DECIDE: begin
          w_state_nxt   = S_SETTLE;
          w_set_cnt_nxt = '0;
          if (r_phase == PH_SAR) begin
            w_code_nxt = w_below ? r_code : (r_code & ~w_bit_mask);
            if (r_bit != '0) begin
              w_code_nxt = w_code_nxt | (w_bit_mask >> 1);
              w_bit_nxt  = r_bit - BIT_W'(1);
            end else begin
              w_phase_nxt = PH_TRACK;
            end
          end else begin
            if (w_too_low) begin
              w_lock_nxt = 1'b0;
              w_code_nxt = (r_code == '1) ? r_code : r_code + CODE_W'(1);
            end else if (w_too_high) begin
              w_lock_nxt = 1'b0;
              w_code_nxt = (r_code == '0) ? r_code : r_code - CODE_W'(1);
            end else begin
              w_lock_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_state    <= S_OFF;
      r_phase    <= PH_SAR;
      r_code     <= CODE_MID;
      r_count    <= '0;
      r_lock     <= 1'b0;
      r_bit      <= BIT_TOP;
      r_set_cnt  <= '0;
      r_win_cnt  <= '0;
      r_win_last <= '0;
      r_edge_cnt <= '0;
      r_target   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_code     <= w_code_nxt;
      r_count    <= w_count_nxt;
      r_lock     <= w_lock_nxt;
      r_bit      <= w_bit_nxt;
      r_set_cnt  <= w_set_cnt_nxt;
      r_win_cnt  <= w_win_cnt_nxt;
      r_win_last <= w_win_last_nxt;
      r_edge_cnt <= w_edge_cnt_nxt;
      r_target   <= w_target_nxt;
    end
  end

  // Two-flop synchronizer for CK_FB plus a history flop for edge detection
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= CK_FB;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Output mapping
  always_comb begin
    PWRUP = (r_state != S_OFF);
    BUSY  = (r_state != S_OFF);
    CODE  = r_code;
    COUNT = r_count;
    LOCK  = r_lock;
  end

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// tb_sun_pll_ctrl: timestamped scoreboard bench for sun_pll_ctrl.
// The feedback-clock model repeats every 128 CK cycles and carries
// clamp(CODE+offset, 0, 64) rising edges per period, so any 128-cycle
// measurement window sees exactly that many edges.
module tb_sun_pll_ctrl;

  localparam int L   = 16 + 128 + 1;  // loop length with WINDOW=128
  localparam int L0  = 16 + 1 + 1;    // loop length with WINDOW=0
  localparam int MW  = 128;

  localparam int F_PWRUP = 0;
  localparam int F_CODE  = 1;
  localparam int F_COUNT = 2;
  localparam int F_BUSY  = 3;
  localparam int F_LOCK  = 4;

  logic       CK;
  logic       RSTN;
  logic       EN;
  logic [9:0] TARGET;
  logic [9:0] WINDOW;
  logic       CK_FB;
  logic       PWRUP;
  logic [5:0] CODE;
  logic [9:0] COUNT;
  logic       BUSY;
  logic       LOCK;

  sun_pll_ctrl #(
    .CODE_W(6),
    .CNT_W(10),
    .WIN_W(10),
    .SETTLE_CYC(16),
    .TOL(2)
  ) dut (
    .CK(CK),
    .RSTN(RSTN),
    .EN(EN),
    .TARGET(TARGET),
    .WINDOW(WINDOW),
    .CK_FB(CK_FB),
    .PWRUP(PWRUP),
    .CODE(CODE),
    .COUNT(COUNT),
    .BUSY(BUSY),
    .LOCK(LOCK)
  );

  typedef struct {
    int    cyc;
    string nm;
    int    fld;
    int    exp;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   offset = 0;
  bit   fb_en = 1'b1;
  int   ph = 0;

  initial CK = 1'b0;
  always #5 CK = ~CK;

  always @(posedge CK) cyc <= cyc + 1;

  // Oscillator plant model
  always @(negedge CK) begin
    int n;
    ph = (ph == MW - 1) ? 0 : ph + 1;
    n = int'(CODE) + offset;
    if (n < 0) n = 0;
    if (n > MW / 2) n = MW / 2;
    CK_FB = fb_en && (ph < 2 * n) && (ph % 2 == 1);
  end

  function automatic int actual(input int fld);
    case (fld)
      F_PWRUP: return int'(PWRUP);
      F_CODE:  return int'(CODE);
      F_COUNT: return int'(COUNT);
      F_BUSY:  return int'(BUSY);
      F_LOCK:  return int'(LOCK);
      default: return -1;
    endcase
  endfunction

  task automatic push_exp(input int c, input string nm, input int fld, input int v);
    exp_t r;
    int   i;
    r.cyc = c;
    r.nm  = nm;
    r.fld = fld;
    r.exp = v;
    i = sbq.size();
    while (i > 0 && sbq[i-1].cyc > c) i--;
    sbq.insert(i, r);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CK);
  endtask

  // Monitor: compares every expectation due at this cycle
  always @(negedge CK) begin
    exp_t r;
    int   a;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      r = sbq.pop_front();
      a = actual(r.fld);
      checks++;
      if (r.cyc != cyc) begin
        failures++;
        $display("FAIL %s: missed at cyc %0d (due %0d) got %0d expected %0d", r.nm, cyc, r.cyc, a, r.exp);
      end else if (a != r.exp) begin
        failures++;
        $display("FAIL %s @cyc %0d: got %0d expected %0d", r.nm, cyc, a, r.exp);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e, e2, e3, e4, e5, e6;
    RSTN   = 1'b0;
    EN     = 1'b0;
    TARGET = 10'd50;
    WINDOW = 10'd128;
    repeat (3) @(negedge CK);

    // Reset state, held with EN=0
    c = cyc;
    push_exp(c + 1,  "rst_pwrup", F_PWRUP, 0);
    push_exp(c + 1,  "rst_code",  F_CODE,  32);
    push_exp(c + 1,  "rst_count", F_COUNT, 0);
    push_exp(c + 1,  "rst_busy",  F_BUSY,  0);
    push_exp(c + 1,  "rst_lock",  F_LOCK,  0);
    push_exp(c + 10, "idle_code", F_CODE,  32);
    push_exp(c + 10, "idle_busy", F_BUSY,  0);
    push_exp(c + 10, "idle_pwrup", F_PWRUP, 0);
    RSTN = 1'b1;
    wait_until(c + 12);

    // SAR to TARGET=50 with count == CODE, then lock
    EN = 1'b1;
    e = cyc + 1;
    push_exp(e,         "en_pwrup",  F_PWRUP, 1);
    push_exp(e,         "en_busy",   F_BUSY,  1);
    push_exp(e,         "en_code",   F_CODE,  32);
    push_exp(e + L - 2, "cnt_pre",   F_COUNT, 0);
    push_exp(e + L - 1, "cnt_l0",    F_COUNT, 32);
    push_exp(e + L - 1, "code_hold", F_CODE,  32);
    push_exp(e + L,     "sar_l1",    F_CODE,  48);
    push_exp(e + 2*L,   "sar_l2",    F_CODE,  56);
    push_exp(e + 3*L,   "sar_l3",    F_CODE,  52);
    push_exp(e + 4*L,   "sar_l4",    F_CODE,  50);
    push_exp(e + 5*L,   "sar_l5",    F_CODE,  49);
    push_exp(e + 6*L - 1, "cnt_l5",  F_COUNT, 49);
    push_exp(e + 6*L,   "trk_code",  F_CODE,  49);
    push_exp(e + 6*L,   "trk_nolock", F_LOCK, 0);
    push_exp(e + 7*L - 1, "lock_pre", F_LOCK, 0);
    push_exp(e + 7*L,   "lock_on",   F_LOCK,  1);
    push_exp(e + 7*L,   "lock_code", F_CODE,  49);

    // Oscillator drifts: count becomes CODE-10, tracking climbs to 58
    push_exp(e + 8*L,    "drift_unlock", F_LOCK, 0);
    push_exp(e + 8*L,    "drift_c50",    F_CODE, 50);
    push_exp(e + 12*L,   "drift_c54",    F_CODE, 54);
    push_exp(e + 16*L,   "drift_c58",    F_CODE, 58);
    push_exp(e + 16*L,   "drift_nolock", F_LOCK, 0);
    push_exp(e + 17*L - 1, "drift_cnt",  F_COUNT, 48);
    push_exp(e + 17*L,   "relock",       F_LOCK, 1);
    push_exp(e + 18*L,   "relock_code",  F_CODE, 58);
    push_exp(e + 18*L,   "relock_hold",  F_LOCK, 1);
    wait_until(e + 7*L + 2);
    offset = -10;
    wait_until(e + 18*L + 5);

    // RSTN pulse while locked and enabled
    c = cyc;
    push_exp(c + 1, "rstp_pwrup", F_PWRUP, 0);
    push_exp(c + 1, "rstp_code",  F_CODE,  32);
    push_exp(c + 1, "rstp_count", F_COUNT, 0);
    push_exp(c + 1, "rstp_busy",  F_BUSY,  0);
    push_exp(c + 1, "rstp_lock",  F_LOCK,  0);
    push_exp(c + 2, "rstp_settle", F_BUSY, 1);
    push_exp(c + 2, "rstp_pwr2",  F_PWRUP, 1);
    RSTN = 1'b0;
    @(negedge CK);
    RSTN = 1'b1;
    e2 = cyc + 1;

    // EN drop mid-MEASURE of SAR bit 3, then re-enable
    push_exp(e2 + L,        "ab_l1",     F_CODE,  48);
    push_exp(e2 + 2*L,      "ab_l2",     F_CODE,  56);
    push_exp(e2 + 2*L + 60, "ab_busy",   F_BUSY,  1);
    push_exp(e2 + 2*L + 61, "ab_pwrup",  F_PWRUP, 0);
    push_exp(e2 + 2*L + 61, "ab_code",   F_CODE,  32);
    push_exp(e2 + 2*L + 61, "ab_lock",   F_LOCK,  0);
    push_exp(e2 + 2*L + 61, "ab_busy0",  F_BUSY,  0);
    push_exp(e2 + 2*L + 61, "ab_count",  F_COUNT, 38);
    push_exp(e2 + 2*L + 64, "ab_idle",   F_CODE,  32);
    wait_until(e2 + 2*L + 60);
    EN = 1'b0;
    wait_until(e2 + 2*L + 65);
    EN = 1'b1;
    e3 = cyc + 1;
    push_exp(e3,         "re_pwrup", F_PWRUP, 1);
    push_exp(e3,         "re_code",  F_CODE,  32);
    push_exp(e3 + L - 1, "re_count", F_COUNT, 22);
    push_exp(e3 + L,     "re_l1",    F_CODE,  48);
    wait_until(e3 + L + 3);

    // TARGET above reachable count: SAR to 63, tracking saturates
    EN = 1'b0;
    TARGET = 10'd1023;
    offset = 0;
    @(negedge CK);
    EN = 1'b1;
    e4 = cyc + 1;
    push_exp(e4 + 5*L,     "hi_sar",    F_CODE,  63);
    push_exp(e4 + 7*L - 1, "hi_count",  F_COUNT, 63);
    push_exp(e4 + 7*L,     "hi_sat",    F_CODE,  63);
    push_exp(e4 + 7*L,     "hi_nolock", F_LOCK,  0);
    push_exp(e4 + 8*L,     "hi_sat2",   F_CODE,  63);
    push_exp(e4 + 8*L,     "hi_nolock2", F_LOCK, 0);
    wait_until(e4 + 8*L + 2);

    // TARGET=0: SAR walks to 0 and locks with lower bound clamped at 0
    EN = 1'b0;
    TARGET = 10'd0;
    @(negedge CK);
    EN = 1'b1;
    e5 = cyc + 1;
    push_exp(e5 + L,       "z_l1",     F_CODE,  16);
    push_exp(e5 + 5*L,     "z_l5",     F_CODE,  1);
    push_exp(e5 + 6*L - 1, "z_cnt5",   F_COUNT, 1);
    push_exp(e5 + 6*L,     "z_l6",     F_CODE,  0);
    push_exp(e5 + 6*L,     "z_nolock", F_LOCK,  0);
    push_exp(e5 + 7*L - 1, "z_cnt6",   F_COUNT, 0);
    push_exp(e5 + 7*L,     "z_lock",   F_LOCK,  1);
    push_exp(e5 + 8*L,     "z_hold",   F_CODE,  0);
    push_exp(e5 + 8*L,     "z_lock2",  F_LOCK,  1);
    wait_until(e5 + 8*L + 2);

    // WINDOW=0 gives one-cycle measurements; no feedback edges
    EN = 1'b0;
    WINDOW = 10'd0;
    TARGET = 10'd5;
    fb_en = 1'b0;
    @(negedge CK);
    EN = 1'b1;
    e6 = cyc + 1;
    push_exp(e6 + L0 - 1, "w0_hold",   F_CODE,  32);
    push_exp(e6 + L0 - 1, "w0_count",  F_COUNT, 0);
    push_exp(e6 + L0,     "w0_l1",     F_CODE,  48);
    push_exp(e6 + 2*L0,   "w0_l2",     F_CODE,  56);
    push_exp(e6 + 5*L0,   "w0_l5",     F_CODE,  63);
    push_exp(e6 + 7*L0,   "w0_sat",    F_CODE,  63);
    push_exp(e6 + 7*L0,   "w0_nolock", F_LOCK,  0);
    wait_until(e6 + 7*L0 + 3);

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
